// File: rtl/water_pkg.sv
// water_pkg: shared widths, fault code, FSM encodings and the thermometer-code decoder
// for the water level encoder.
package water_pkg;
    localparam int LEVEL_W = 3;
    localparam int PROBE_N = 6;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd6;
    localparam logic [LEVEL_W-1:0] STATE_FAULT = 3'd7;

    typedef enum logic {S_TRACK, S_FAULT} fsm_t;

    typedef struct packed {
        logic               valid;
        logic [LEVEL_W-1:0] level;
    } dec_t;

    // A thermometer code 2^k-1 has no set bit above a clear bit, so p & (p+1) is zero.
    function automatic dec_t decode(input logic [PROBE_N-1:0] p);
        decode.valid = (p & (p + PROBE_N'(1))) == '0;
        decode.level = LEVEL_W'($countones(p));
    endfunction
endpackage

// File: rtl/water_level_encoder_if.sv
// water_level_encoder_if: probe inputs and level outputs between the encoder (master)
// and its environment (slave).
interface water_level_encoder_if;
    import water_pkg::*;
    logic [PROBE_N-1:0] sensor;
    logic [LEVEL_W-1:0] state;
    logic               state_valid;
    logic               fault;

    modport master (input sensor, output state, state_valid, fault);
    modport slave  (output sensor, input state, state_valid, fault);
endinterface

// File: rtl/sample_tick.sv
// sample_tick: one-cycle pulse every DIV clk cycles, first pulse DIV cycles after reset.
module sample_tick #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    logic [15:0] r_cnt;

    assign tick = r_cnt == 16'(DIV - 1);

    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= tick ? '0 : r_cnt + 16'd1;
    end
endmodule

// File: rtl/water_level_encoder.sv
// water_level_encoder: synchronises, debounces and decodes six thermometer-coded probes
// into a 0..6 level or fault code 7; LEVEL_SLEW_EN makes the level walk one step per tick.
module water_level_encoder
    import water_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000,
    parameter int STABLE_CNT = 4
) (
    input logic                  clk,
    input logic                  rst,
    water_level_encoder_if.master bus
);
    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CNT);

    logic               w_tick, w_same, w_commit;
    logic [PROBE_N-1:0] r_sync1, r_sync2, r_cand, r_committed;
    logic [3:0]         r_stable, w_stable_nx;
    dec_t               w_dec;
    fsm_t               r_fsm, w_fsm_nx;
    logic [LEVEL_W-1:0] r_state, w_state_nx, r_target, w_target_nx;
    logic               r_valid;

    sample_tick #(.DIV(SAMPLE_DIV)) u_tick (.clk(clk), .rst(rst), .tick(w_tick));

    assign w_same      = r_sync2 == r_cand;
    assign w_stable_nx = !w_same ? 4'd1 : (r_stable == STABLE_MAX) ? r_stable : r_stable + 4'd1;
    assign w_commit    = w_tick && w_stable_nx == STABLE_MAX && r_sync2 != r_committed;
    assign w_dec       = decode(r_sync2);

    always_comb begin
        w_fsm_nx    = r_fsm;
        w_state_nx  = r_state;
        w_target_nx = (w_commit && w_dec.valid) ? w_dec.level : r_target;
        case (r_fsm)
            S_TRACK: begin
                if (w_commit && !w_dec.valid) begin
                    w_fsm_nx   = S_FAULT;
                    w_state_nx = STATE_FAULT;
                end
`ifdef LEVEL_SLEW_EN
                else if (w_tick && r_state != w_target_nx)
                    w_state_nx = (r_state < w_target_nx) ? r_state + 3'd1 : r_state - 3'd1;
`else
                else if (w_commit)
                    w_state_nx = w_dec.level;
`endif
            end
            S_FAULT: begin
                if (w_commit && w_dec.valid) begin
                    w_fsm_nx   = S_TRACK;
                    w_state_nx = w_dec.level;
                end
            end
            default: w_fsm_nx = S_TRACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_cand      <= '0;
            r_stable    <= '0;
            r_committed <= '0;
            r_fsm       <= S_TRACK;
            r_state     <= '0;
            r_target    <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_sync1     <= bus.sensor;
            r_sync2     <= r_sync1;
            if (w_tick) begin
                r_cand   <= r_sync2;
                r_stable <= w_stable_nx;
            end
            if (w_commit) r_committed <= r_sync2;
            r_fsm       <= w_fsm_nx;
            r_state     <= w_state_nx;
            r_target    <= w_target_nx;
            r_valid     <= w_state_nx != r_state;
        end
    end

    assign bus.state       = r_state;
    assign bus.state_valid = r_valid;
    assign bus.fault       = r_fsm == S_FAULT;
endmodule

// File: tb/tb_water_level_encoder.sv
// tb_water_level_encoder: scoreboard bench; expected {fault,state} pushed when the probes
// change, popped on every state_valid pulse. Honours LEVEL_SLEW_EN when defined.
module tb_water_level_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] m_cnt;
    logic [3:0] q[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         n_pulse = 0;
    int         n_push = 0;
    int         n0;

    water_level_encoder_if bus ();

    water_level_encoder #(.SAMPLE_DIV(4), .STABLE_CNT(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference tick: the DUT ticks on the edge where this counter reads 3.
    always @(posedge clk) m_cnt <= rst ? 2'd0 : m_cnt + 2'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.state_valid === 1'b1) begin
            n_pulse++;
            if (q.size() == 0) chk("spurious_pulse", 1, 0);
            else begin
                logic [3:0] e;
                e = q.pop_front();
                chk("sb_state", bus.state, e[2:0]);
                chk("sb_fault", bus.fault, e[3]);
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge clk iff m_cnt == 2'd3);
        #1;
    endtask

    task automatic push(input int lvl);
        q.push_back({lvl == 7, 3'(lvl)});
        n_push++;
    endtask

    // Drive a new probe pattern and expect it to land on the third tick (plus slew steps).
    task automatic sb_commit(input string tag, input logic [5:0] s, input int from, input int to,
                             input bit jump);
        int extra;
        int l;
        extra = 0;
        bus.sensor = s;
`ifdef LEVEL_SLEW_EN
        if (!jump) begin
            extra = ((to > from) ? to - from : from - to) - 1;
            l = from;
            while (l != to) begin
                l = l + ((to > from) ? 1 : -1);
                push(l);
            end
        end else
`endif
        push(to);
        wait_ticks(2);
        chk({tag, "_hold"}, bus.state, from);
        wait_ticks(1 + extra);
        chk(tag, bus.state, to);
        chk({tag, "_fault"}, bus.fault, to == 7);
        @(negedge clk);
        #1 chk({tag, "_drain"}, q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.sensor = 6'b000111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", bus.state, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_valid", bus.state_valid, 0);
        rst = 1'b0;
        sb_commit("rst_lvl3", 6'b000111, 0, 3, 0);
        sb_commit("step", 6'b011111, 3, 5, 0);

        n0 = n_pulse;
        for (int i = 0; i < 10; i++) begin
            bus.sensor = i[0] ? 6'b000011 : 6'b000001;
            wait_ticks(2);
        end
        chk("bounce_state", bus.state, 5);
        chk("bounce_pulses", n_pulse - n0, 0);

        sb_commit("fault_in", 6'b010101, 5, 7, 1);
        n0 = n_pulse;
        bus.sensor = 6'b001010;
        wait_ticks(4);
        chk("inv_inv_state", bus.state, 7);
        chk("inv_inv_fault", bus.fault, 1);
        chk("inv_inv_pulses", n_pulse - n0, 0);
        sb_commit("fault_out", 6'b000000, 7, 0, 1);

        sb_commit("full", 6'b111111, 0, 6, 0);
        sb_commit("empty", 6'b000000, 6, 0, 0);
        sb_commit("lvl2", 6'b000011, 0, 2, 0);

        bus.sensor = 6'b001111;
        wait_ticks(2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_state", bus.state, 0);
        chk("midrst_fault", bus.fault, 0);
        chk("midrst_valid", bus.state_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        sb_commit("post_rst", 6'b001111, 0, 4, 0);

        chk("pulse_total", n_pulse, n_push);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
